ram_arbiter: RTL

RAM_ARBITER -- requirements
Module: ram_arbiter

---
 rtl/ram_arb_pkg.sv | 26 ++
 rtl/ram_arbiter_rr_arb2.sv | 14 +
 rtl/ram_arbiter.sv | 120 ++++++++++++
 3 files changed

// File: rtl/ram_arb_pkg.sv
// Shared types and defaults for the two-port RAM arbiter: FSM state encoding,
// width defaults and the round-robin pick rule.
`timescale 1ns/1ps
package ram_arb_pkg;

    localparam int AW_DEF = 8;
    localparam int DW_DEF = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    // i_last is the id granted most recently; on a tie the other requester wins.
    function automatic logic rr_pick(input logic i_req0, input logic i_req1, input logic i_last);
        logic w_pick;
        if (i_req0 && i_req1) begin
            w_pick = ~i_last;
        end else begin
            w_pick = i_req1;
        end
        return w_pick;
    endfunction

endpackage

// File: rtl/ram_arbiter_rr_arb2.sv
// Two-input round-robin selector; o_winner is only meaningful when a request is present.
`timescale 1ns/1ps
module rr_arb2
    import ram_arb_pkg::*;
(
    input  logic i_req0,
    input  logic i_req1,
    input  logic i_pointer,
    output logic o_winner
);

    assign o_winner = rr_pick(i_req0, i_req1, i_pointer);

endmodule

// File: rtl/ram_arbiter.sv
// Shares one single-port RAM between a CPU (id 0) and a loader/DMA (id 1):
// arbitrate in IDLE, drive the RAM in ACCESS, pulse ack in RESP.
`timescale 1ns/1ps
module ram_arbiter
    import ram_arb_pkg::*;
#(
    parameter int AW = AW_DEF,
    parameter int DW = DW_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req0,
    input  logic          req1,
    input  logic          we0,
    input  logic          we1,
    input  logic [AW-1:0] addr0,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] wdata0,
    input  logic [DW-1:0] wdata1,
    output logic          ack0,
    output logic          ack1,
    output logic [DW-1:0] rdata0,
    output logic [DW-1:0] rdata1,
    output logic          busy,
    output logic          ram_we,
    output logic          ram_re,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_wdata,
    input  logic [DW-1:0] ram_rdata
);

    state_t        r_state;
    logic          r_last;
    logic          r_id;
    logic          r_we;
    logic [AW-1:0] r_addr;
    logic [DW-1:0] r_wdata;

    logic          w_any;
    logic          w_winner;
    logic          w_access;
    logic          w_resp;
    logic [1:0]    w_ack;
    logic [DW-1:0] w_rdata [2];

    assign w_any = req0 | req1;

    rr_arb2 u_rr_arb2 (
        .i_req0    (req0),
        .i_req1    (req1),
        .i_pointer (r_last),
        .o_winner  (w_winner)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_last  <= 1'b1;
            r_id    <= 1'b0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_any) begin
                        r_id    <= w_winner;
                        r_we    <= w_winner ? we1    : we0;
                        r_addr  <= w_winner ? addr1  : addr0;
                        r_wdata <= w_winner ? wdata1 : wdata0;
                        r_state <= ACCESS;
                    end
                end
                ACCESS: begin
                    r_state <= RESP;
                end
                RESP: begin
                    r_last  <= r_id;
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    // Gating with rst keeps a reset that lands mid-access from committing a write or acking.
    assign w_access = (r_state == ACCESS) && !rst;
    assign w_resp   = (r_state == RESP)   && !rst;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_port
            logic [DW-1:0] r_rdata;

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_rdata <= '0;
                end else if ((r_state == ACCESS) && !r_we && (r_id == 1'(gi))) begin
                    r_rdata <= ram_rdata;
                end
            end

            assign w_rdata[gi] = rst ? '0 : r_rdata;
            assign w_ack[gi]   = w_resp && (r_id == 1'(gi));
        end
    endgenerate

    assign ack0      = w_ack[0];
    assign ack1      = w_ack[1];
    assign rdata0    = w_rdata[0];
    assign rdata1    = w_rdata[1];
    assign busy      = (r_state != IDLE) && !rst;
    assign ram_we    = w_access && r_we;
    assign ram_re    = w_access && !r_we;
    assign ram_addr  = rst ? '0 : r_addr;
    assign ram_wdata = rst ? '0 : r_wdata;

endmodule
